// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: writeback has priority, aux gets a forced slot when starved.
// Optional post-reset clear walk over all registers is enabled by defining REGFILE_CLEAR_EN.
module regfile_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_REGS   = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              aux_valid,
    input  logic [ADDR_W-1:0] aux_rd,
    input  logic [DATA_W-1:0] aux_data,
    output logic              aux_ready,
    output logic              wb_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              clear_busy
);

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);
    localparam logic [3:0] STARVE_SAT  = 4'(STARVE_MAX);

    // Out-of-range configurations show up as a named block in the elaborated hierarchy.
    if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_W) || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_config
    end

    logic [3:0] starve_cnt_reg, starve_cnt_next;
    logic       force_aux_reg, force_aux_next;
    logic       wb_stall_reg, wb_stall_next;
    logic       clear_busy_reg, clear_busy_next;

    logic              in_clear;
    logic              clear_done;
    logic [ADDR_W-1:0] clear_addr;

    logic wb_req, grant_wb, grant_aux, aux_denied;

`ifdef REGFILE_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic              HOLD_AT_RESET = 1'b1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        clear_done   = 1'b0;
        if (state_reg == ST_CLEAR) begin
            clr_idx_next = clr_idx_reg + 1'b1;
            if (clr_idx_reg == CLR_LAST) begin
                state_next   = ST_RUN;
                clr_idx_next = '0;
                clear_done   = 1'b1;
            end
        end
    end

    assign in_clear   = (state_reg == ST_CLEAR);
    assign clear_addr = clr_idx_reg;
`else
    localparam logic HOLD_AT_RESET = 1'b0;

    assign in_clear   = 1'b0;
    assign clear_done = 1'b0;
    assign clear_addr = '0;
`endif

    always_comb begin
        wb_req    = wb_we & (wb_rd != '0) & ~wb_stall_reg;
        grant_wb  = 1'b0;
        grant_aux = 1'b0;
        if (force_aux_reg && aux_valid) begin
            grant_aux = 1'b1;
        end else if (wb_req) begin
            grant_wb = 1'b1;
        end else if (aux_valid) begin
            grant_aux = 1'b1;
        end
    end

    // Write-port mux; aux writes to x0 complete the handshake but never assert WE3.
    always_comb begin
        rf_we     = 1'b0;
        rf_addr   = '0;
        rf_wdata  = '0;
        aux_ready = 1'b0;
        if (rst) begin
            if (in_clear) begin
                rf_we   = 1'b1;
                rf_addr = clear_addr;
            end else if (grant_wb) begin
                rf_we    = 1'b1;
                rf_addr  = wb_rd;
                rf_wdata = wb_data;
            end else if (grant_aux) begin
                aux_ready = 1'b1;
                rf_we     = (aux_rd != '0);
                rf_addr   = aux_rd;
                rf_wdata  = aux_data;
            end
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        force_aux_next  = 1'b0;
        wb_stall_next   = 1'b0;
        clear_busy_next = 1'b0;
        aux_denied      = aux_valid & ~aux_ready;
        if (in_clear) begin
            starve_cnt_next = '0;
            wb_stall_next   = ~clear_done;
            clear_busy_next = ~clear_done;
        end else begin
            if (!aux_denied) begin
                starve_cnt_next = '0;
            end else if (starve_cnt_reg < STARVE_SAT) begin
                starve_cnt_next = starve_cnt_reg + 4'd1;
            end
            // The forced slot is a single stall cycle; it cannot re-arm on itself.
            force_aux_next = aux_denied & (starve_cnt_reg >= STARVE_LAST);
            wb_stall_next  = force_aux_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_reg <= '0;
            force_aux_reg  <= 1'b0;
            wb_stall_reg   <= HOLD_AT_RESET;
            clear_busy_reg <= HOLD_AT_RESET;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            force_aux_reg  <= force_aux_next;
            wb_stall_reg   <= wb_stall_next;
            clear_busy_reg <= clear_busy_next;
        end
    end

    assign wb_stall   = wb_stall_reg;
    assign clear_busy = clear_busy_reg;

endmodule
